// File: rtl/mem_stage_pipe.sv
//------------------------------------------------------------------------------
// Module      : mem_stage_pipe
// Description : Pipelined CPU memory stage. Holds the EX/MEM (M) and MEM/WB (W)
//               registers, runs dcache requests with a dhit handshake, selects
//               the writeback value, freezes upstream through mem_stall, makes
//               halt sticky and flags requests that never complete.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int REG_W    = 5,
   parameter int WAIT_MAX = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ex_valid,
   input  logic              ex_dREN,
   input  logic              ex_dWEN,
   input  logic              ex_RegWEN,
   input  logic              ex_MtR,
   input  logic              ex_JAL,
   input  logic              ex_LUI,
   input  logic              ex_halt,
   input  logic [DATA_W-1:0] ex_alu_out,
   input  logic [DATA_W-1:0] ex_wdat,
   input  logic [DATA_W-1:0] ex_n_pc,
   input  logic [DATA_W-1:0] ex_immload,
   input  logic [REG_W-1:0]  ex_wsel,
   input  logic              flush,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [DATA_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic              wb_valid,
   output logic              wb_RegWEN,
   output logic [REG_W-1:0]  wb_wsel,
   output logic [DATA_W-1:0] wb_wdat,
   output logic              wb_halt,
   output logic              err
);

   // Wait counter is wide enough to hold WAIT_MAX itself so it can saturate there.
   localparam int c_cnt_w = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_wait_max  = c_cnt_w'(WAIT_MAX);
   localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t              r_state;

   // EX/MEM register
   logic                r_m_valid;
   logic                r_m_dren;
   logic                r_m_dwen;
   logic                r_m_regwen;
   logic                r_m_mtr;
   logic                r_m_jal;
   logic                r_m_lui;
   logic                r_m_halt;
   logic [DATA_W-1:0]   r_m_alu_out;
   logic [DATA_W-1:0]   r_m_wdat;
   logic [DATA_W-1:0]   r_m_n_pc;
   logic [DATA_W-1:0]   r_m_immload;
   logic [REG_W-1:0]    r_m_wsel;

   // MEM/WB register
   logic                r_w_valid;
   logic                r_w_regwen;
   logic [REG_W-1:0]    r_w_wsel;
   logic [DATA_W-1:0]   r_w_wdat;

   // Watchdog
   logic [c_cnt_w-1:0]  r_wait_cnt;
   logic                r_err;

   logic                w_run;
   logic                w_m_mem;
   logic                w_wait;
   logic                w_advance;
   logic [DATA_W-1:0]   w_result;

   assign w_run     = (r_state == ST_RUN);
   assign w_m_mem   = r_m_valid & (r_m_dren | r_m_dwen) & w_run;
   assign w_wait    = w_m_mem & ~dhit;
   // In HALT nothing moves; in RUN everything moves unless a request is pending.
   assign w_advance = w_run & ~w_wait;

   // Writeback value select; load data is taken on the dhit cycle itself.
   always_comb begin
      w_result = r_m_alu_out;
      if (r_m_mtr) begin
         w_result = dmemload;
      end else if (r_m_jal) begin
         w_result = r_m_n_pc;
      end else if (r_m_lui) begin
         w_result = r_m_immload;
      end
   end

   assign dmemREN   = w_m_mem & r_m_dren;
   assign dmemWEN   = w_m_mem & r_m_dwen;
   assign dmemaddr  = r_m_alu_out;
   assign dmemstore = r_m_wdat;
   assign mem_stall = w_wait | ~w_run;

   // The halt instruction itself (and anything behind it) never shows as valid.
   assign wb_valid  = r_w_valid & w_run;
   assign wb_RegWEN = wb_valid & r_w_regwen & (r_w_wsel != '0);
   assign wb_wsel   = r_w_wsel;
   assign wb_wdat   = r_w_wdat;
   assign wb_halt   = ~w_run;
   assign err       = r_err;

   // EX/MEM capture: only on advance edges, so a flush during a stall is ignored.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_m_valid   <= 1'b0;
         r_m_dren    <= 1'b0;
         r_m_dwen    <= 1'b0;
         r_m_regwen  <= 1'b0;
         r_m_mtr     <= 1'b0;
         r_m_jal     <= 1'b0;
         r_m_lui     <= 1'b0;
         r_m_halt    <= 1'b0;
         r_m_alu_out <= '0;
         r_m_wdat    <= '0;
         r_m_n_pc    <= '0;
         r_m_immload <= '0;
         r_m_wsel    <= '0;
      end else if (w_advance) begin
         r_m_valid   <= ex_valid & ~flush;
         r_m_dren    <= ex_dREN;
         r_m_dwen    <= ex_dWEN;
         r_m_regwen  <= ex_RegWEN;
         r_m_mtr     <= ex_MtR;
         r_m_jal     <= ex_JAL;
         r_m_lui     <= ex_LUI;
         r_m_halt    <= ex_halt;
         r_m_alu_out <= ex_alu_out;
         r_m_wdat    <= ex_wdat;
         r_m_n_pc    <= ex_n_pc;
         r_m_immload <= ex_immload;
         r_m_wsel    <= ex_wsel;
      end
   end

   // MEM/WB capture; stall and halt cycles insert a bubble so writes happen once.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_w_valid  <= 1'b0;
         r_w_regwen <= 1'b0;
         r_w_wsel   <= '0;
         r_w_wdat   <= '0;
      end else if (w_advance) begin
         r_w_valid  <= r_m_valid;
         r_w_regwen <= r_m_regwen;
         r_w_wsel   <= r_m_wsel;
         r_w_wdat   <= w_result;
      end else begin
         r_w_valid  <= 1'b0;
         r_w_regwen <= 1'b0;
         r_w_wsel   <= '0;
         r_w_wdat   <= '0;
      end
   end

   // Run/halt control: halt becomes sticky on the edge the halt enters W.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_advance & r_m_valid & r_m_halt) begin
                  r_state <= ST_HALT;
               end
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   // Watchdog: count consecutive unanswered request cycles, latch err at the limit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else if (w_wait) begin
         if (r_wait_cnt != c_wait_max) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_one;
         end
         if ((WAIT_MAX != 0) && (r_wait_cnt == c_wait_last)) begin
            r_err <= 1'b1;
         end
      end else begin
         r_wait_cnt <= '0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_stage_pipe
// Description : Self-checking bench for mem_stage_pipe: directed scenarios with
//               literal expectations plus randomized traffic against a
//               stage-level behavioural model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stage_pipe;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int WM = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          ex_valid, ex_dREN, ex_dWEN, ex_RegWEN, ex_MtR, ex_JAL, ex_LUI, ex_halt;
   logic [DW-1:0] ex_alu_out, ex_wdat, ex_n_pc, ex_immload;
   logic [RW-1:0] ex_wsel;
   logic          flush, dhit;
   logic [DW-1:0] dmemload;
   logic          dmemREN, dmemWEN, mem_stall, wb_valid, wb_RegWEN, wb_halt, err;
   logic [DW-1:0] dmemaddr, dmemstore, wb_wdat;
   logic [RW-1:0] wb_wsel;

   mem_stage_pipe #(.DATA_W(DW), .REG_W(RW), .WAIT_MAX(WM)) dut (
      .CLK(CLK), .RST(RST),
      .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_RegWEN(ex_RegWEN),
      .ex_MtR(ex_MtR), .ex_JAL(ex_JAL), .ex_LUI(ex_LUI), .ex_halt(ex_halt),
      .ex_alu_out(ex_alu_out), .ex_wdat(ex_wdat), .ex_n_pc(ex_n_pc),
      .ex_immload(ex_immload), .ex_wsel(ex_wsel), .flush(flush), .dhit(dhit),
      .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
      .wb_valid(wb_valid), .wb_RegWEN(wb_RegWEN), .wb_wsel(wb_wsel),
      .wb_wdat(wb_wdat), .wb_halt(wb_halt), .err(err)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Instruction as seen by the memory stage
   typedef struct packed {
      logic          valid, dren, dwen, regwen, mtr, jal, lui, halt;
      logic [DW-1:0] alu, wdat, npc, imm;
      logic [RW-1:0] wsel;
   } ins_t;

   // Model state: instruction in the memory stage, retired result, run/halt, watchdog
   ins_t          md;
   logic          mw_valid, mw_regwen;
   logic [RW-1:0] mw_wsel;
   logic [DW-1:0] mw_wdat;
   logic          m_halted, m_err;
   int            m_cnt;
   int            lat_left;
   logic          chk_en = 1'b0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ins_t cur_ex();
      ins_t t;
      t.valid  = ex_valid & ~flush;
      t.dren   = ex_dREN;   t.dwen = ex_dWEN; t.regwen = ex_RegWEN;
      t.mtr    = ex_MtR;    t.jal  = ex_JAL;  t.lui    = ex_LUI;  t.halt = ex_halt;
      t.alu    = ex_alu_out; t.wdat = ex_wdat; t.npc = ex_n_pc; t.imm = ex_immload;
      t.wsel   = ex_wsel;
      return t;
   endfunction

   // One clock edge of the stage, at the instruction/transaction level.
   task automatic model_step();
      logic req;
      if (RST) begin
         md = '0; mw_valid = 0; mw_regwen = 0; mw_wsel = '0; mw_wdat = '0;
         m_halted = 0; m_err = 0; m_cnt = 0; lat_left = 0;
      end else if (m_halted) begin
         mw_valid = 0; mw_regwen = 0; m_cnt = 0;
      end else begin
         req = md.valid && (md.dren || md.dwen);
         if (req && !dhit) begin
            m_cnt++;
            if (m_cnt == WM) m_err = 1;
            mw_valid = 0; mw_regwen = 0;
            if (lat_left > 0) lat_left--;
         end else begin
            m_cnt     = 0;
            mw_valid  = md.valid;
            mw_regwen = md.regwen;
            mw_wsel   = md.wsel;
            if (md.mtr)      mw_wdat = dmemload;
            else if (md.jal) mw_wdat = md.npc;
            else if (md.lui) mw_wdat = md.imm;
            else             mw_wdat = md.alu;
            if (md.valid && md.halt) m_halted = 1;
            md       = cur_ex();
            lat_left = int'($urandom_range(0, 3));
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      model_step();
   endtask

   // Compare every DUT output with the model, mid-cycle.
   logic e_req, e_wbv;
   always @(negedge CLK) begin
      if (chk_en) begin
         e_req = !m_halted && md.valid && (md.dren || md.dwen);
         e_wbv = mw_valid && !m_halted;
         chk1 ("dmemREN",   dmemREN,   e_req && md.dren);
         chk1 ("dmemWEN",   dmemWEN,   e_req && md.dwen);
         chk32("dmemaddr",  dmemaddr,  md.alu);
         chk32("dmemstore", dmemstore, md.wdat);
         chk1 ("mem_stall", mem_stall, m_halted || (e_req && !dhit));
         chk1 ("wb_valid",  wb_valid,  e_wbv);
         chk1 ("wb_RegWEN", wb_RegWEN, e_wbv && mw_regwen && (mw_wsel != '0));
         chk1 ("wb_halt",   wb_halt,   m_halted);
         chk1 ("err",       err,       m_err);
         if (e_wbv) begin
            chk32("wb_wsel", 32'(wb_wsel), 32'(mw_wsel));
            chk32("wb_wdat", wb_wdat, mw_wdat);
         end
      end
   end

   task automatic ex_idle();
      ex_valid = 0; ex_dREN = 0; ex_dWEN = 0; ex_RegWEN = 0; ex_MtR = 0;
      ex_JAL = 0; ex_LUI = 0; ex_halt = 0; flush = 0;
      ex_alu_out = '0; ex_wdat = '0; ex_n_pc = '0; ex_immload = '0; ex_wsel = '0;
   endtask

   task automatic ex_alu(input logic [DW-1:0] a, input logic [RW-1:0] ws);
      ex_idle();
      ex_valid = 1; ex_RegWEN = 1; ex_alu_out = a; ex_wsel = ws;
      ex_n_pc = 32'h1111_0004; ex_immload = 32'h2222_0000;
   endtask

   task automatic ex_load(input logic [DW-1:0] a, input logic [RW-1:0] ws);
      ex_idle();
      ex_valid = 1; ex_dREN = 1; ex_RegWEN = 1; ex_MtR = 1; ex_alu_out = a; ex_wsel = ws;
   endtask

   task automatic ex_store(input logic [DW-1:0] a, input logic [DW-1:0] d);
      ex_idle();
      ex_valid = 1; ex_dWEN = 1; ex_alu_out = a; ex_wdat = d;
   endtask

   task automatic do_reset();
      RST = 1; ex_idle(); dhit = 0; dmemload = '0;
      tick(); tick();
      RST = 0;
   endtask

   initial begin
      int halt_cyc;
      int k;
      RST = 1; ex_idle(); dhit = 0; dmemload = '0;
      tick();
      chk_en = 1;
      tick();
      RST = 0;
      #1;
      chk1 ("rst_wb_valid",  wb_valid,  0);
      chk1 ("rst_dmemREN",   dmemREN,   0);
      chk1 ("rst_mem_stall", mem_stall, 0);
      chk1 ("rst_wb_halt",   wb_halt,   0);
      chk1 ("rst_err",       err,       0);
      chk32("rst_wb_wdat",   wb_wdat,   0);

      // ALU op reaches writeback two edges after presentation, for one cycle
      ex_alu(32'h10, 5'd3);
      tick(); ex_idle();
      tick();
      chk32("t1_wdat", wb_wdat, 32'h10);
      chk32("t1_wsel", 32'(wb_wsel), 32'd3);
      chk1 ("t1_wen",  wb_RegWEN, 1);
      tick();
      chk1 ("t1_once", wb_RegWEN, 0);

      // Load with three wait cycles, followed by an ALU op that must survive
      ex_load(32'h40, 5'd7);
      tick();
      ex_alu(32'h77, 5'd4);
      for (int i = 0; i < 3; i++) begin
         dhit = 0; #1;
         chk1 ("t2_ren",   dmemREN,   1);
         chk1 ("t2_stall", mem_stall, 1);
         chk32("t2_addr",  dmemaddr,  32'h40);
         tick();
      end
      dhit = 1; dmemload = 32'hDEAD; #1;
      chk1("t2_nostall", mem_stall, 0);
      tick(); ex_idle(); dhit = 0; dmemload = '0;
      chk32("t2_wdat", wb_wdat, 32'hDEAD);
      chk1 ("t2_wen",  wb_RegWEN, 1);
      tick();
      chk32("t2_next_wdat", wb_wdat, 32'h77);
      chk32("t2_next_wsel", 32'(wb_wsel), 32'd4);

      // Zero-wait store
      ex_store(32'h80, 32'h5);
      tick(); ex_idle(); dhit = 1; #1;
      chk1 ("t3_wen",   dmemWEN,   1);
      chk1 ("t3_stall", mem_stall, 0);
      chk32("t3_addr",  dmemaddr,  32'h80);
      chk32("t3_data",  dmemstore, 32'h5);
      tick(); dhit = 0; #1;
      chk1("t3_wen_once", dmemWEN,   0);
      chk1("t3_noreg",    wb_RegWEN, 0);
      chk1("t3_retired",  wb_valid,  1);

      // Flushed load never requests; flush during a stall is ignored
      ex_load(32'h44, 5'd2); flush = 1;
      tick(); ex_idle(); #1;
      chk1("t4_noreq", dmemREN, 0);
      tick();
      chk1("t4_novalid", wb_valid, 0);
      ex_load(32'h48, 5'd6);
      tick(); ex_alu(32'h99, 5'd9); flush = 1; dhit = 0;
      tick(); #1;
      chk32("t4_hold_addr", dmemaddr, 32'h48);
      chk1 ("t4_hold_req",  dmemREN,  1);
      flush = 0; dhit = 1; dmemload = 32'h1234;
      tick(); ex_idle(); dhit = 0;
      chk32("t4_load", wb_wdat, 32'h1234);
      tick();
      chk32("t4_after", wb_wdat, 32'h99);
      chk1 ("t4_after_v", wb_valid, 1);

      // Halt then three ALU ops: halt is sticky, nothing else retires
      ex_idle(); ex_valid = 1; ex_halt = 1;
      tick();
      for (int i = 1; i <= 3; i++) begin
         ex_alu(32'(i), 5'(i));
         tick();
      end
      ex_load(32'h200, 5'd5);
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         chk1("t5_halt",  wb_halt,   1);
         chk1("t5_noreg", wb_RegWEN, 0);
         chk1("t5_noreq", dmemREN,   0);
      end
      do_reset();

      // Watchdog at WAIT_MAX=4, then reset mid-wait
      ex_load(32'h100, 5'd1);
      tick(); ex_idle(); dhit = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk1("t6_err", err,     (i >= 4));
         chk1("t6_req", dmemREN, 1);
      end
      RST = 1;
      tick(); RST = 0; #1;
      chk1 ("t6_rst_req",   dmemREN,   0);
      chk1 ("t6_rst_err",   err,       0);
      chk1 ("t6_rst_stall", mem_stall, 0);
      chk1 ("t6_rst_wbv",   wb_valid,  0);
      chk32("t6_rst_addr",  dmemaddr,  32'h0);

      // Randomized traffic
      halt_cyc = 0;
      for (int c = 0; c < 3000; c++) begin
         RST = ($urandom_range(0, 299) == 0) || (m_halted && halt_cyc > 3);
         k = int'($urandom_range(0, 3));
         ex_valid   = ($urandom_range(0, 3) != 0);
         ex_dREN    = (k == 1);
         ex_dWEN    = (k == 2);
         ex_RegWEN  = ($urandom_range(0, 1) == 1);
         ex_MtR     = (k == 1) || ($urandom_range(0, 7) == 0);
         ex_JAL     = ($urandom_range(0, 3) == 0);
         ex_LUI     = ($urandom_range(0, 3) == 0);
         ex_halt    = ($urandom_range(0, 127) == 0);
         ex_alu_out = $urandom; ex_wdat = $urandom;
         ex_n_pc    = $urandom; ex_immload = $urandom;
         ex_wsel    = 5'($urandom_range(0, 31));
         flush      = ($urandom_range(0, 7) == 0);
         dmemload   = $urandom;
         if (!m_halted && md.valid && (md.dren || md.dwen)) dhit = (lat_left == 0);
         else                                               dhit = ($urandom_range(0, 1) == 1);
         halt_cyc = m_halted ? halt_cyc + 1 : 0;
         tick();
      end
      RST = 0; ex_idle(); dhit = 0;
      tick();
      chk_en = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
